// File: rtl/mmu_translate.sv
// Address-translation stage: walks a process's page chain and allocates a page on a miss.
// Define MMU_CACHE_EN to add a one-entry {seg, tgt} -> ppage translation cache.
module mmu_translate #(
  parameter int ADDR_W    = 10,
  parameter int PAGE_BITS = 3
) (
  input  logic                          rst,
  input  logic                          clka,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_laddr,
  input  logic [ADDR_W-PAGE_BITS-1:0]   req_start_seg,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ADDR_W-1:0]             resp_paddr,
  output logic                          resp_fault
);
  localparam int PAGE_W    = ADDR_W - PAGE_BITS;
  localparam int NUM_PAGES = 1 << PAGE_W;
  localparam logic [PAGE_W-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {IDLE, WALK, SCAN, LINK, RESP} state_t;
  state_t state, state_nx;

  logic [NUM_PAGES-1:0] used;
  logic [PAGE_W-1:0]    nxt   [NUM_PAGES];
  logic [PAGE_W-1:0]    lpage [NUM_PAGES];

  logic [PAGE_W-1:0]    tgt, seg, cur, last, scan, ppage, hint, cnt;
  logic [PAGE_BITS-1:0] off;
  logic                 fault;

  logic [PAGE_W-1:0] req_tgt;
  logic              cache_hit;
  logic [PAGE_W-1:0] cache_pp;
  logic              walk_hit, walk_end, cnt_max;

  assign req_tgt  = req_laddr[ADDR_W-1:PAGE_BITS];
  assign walk_hit = (cur != seg) && (lpage[cur] == tgt);
  assign walk_end = (nxt[cur] == '0);
  // One counter serves both the walk step limit and the scan slot limit.
  assign cnt_max  = (cnt == LAST_IDX);

`ifdef MMU_CACHE_EN
  logic              c_vld;
  logic [PAGE_W-1:0] c_seg, c_tgt, c_pp;

  assign cache_hit = c_vld && (c_seg == req_start_seg) && (c_tgt == req_tgt) && (req_tgt != '0);
  assign cache_pp  = c_pp;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      c_vld <= 1'b0;
      c_seg <= '0;
      c_tgt <= '0;
      c_pp  <= '0;
    end else if (state == RESP && resp_ready && !fault && tgt != '0) begin
      c_vld <= 1'b1;
      c_seg <= seg;
      c_tgt <= tgt;
      c_pp  <= ppage;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_pp  = '0;
`endif

  always_ff @(posedge clka or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = (req_tgt == '0 || cache_hit) ? RESP : WALK;
      WALK: begin
        if (walk_hit)      state_nx = RESP;
        else if (walk_end) state_nx = SCAN;
        else if (cnt_max)  state_nx = RESP;
      end
      SCAN: begin
        if (!used[scan])   state_nx = LINK;
        else if (cnt_max)  state_nx = RESP;
      end
      LINK: state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      tgt   <= '0;
      seg   <= '0;
      off   <= '0;
      cur   <= '0;
      last  <= '0;
      scan  <= '0;
      ppage <= '0;
      cnt   <= '0;
      fault <= 1'b0;
      hint  <= PAGE_W'(1);
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          tgt   <= req_tgt;
          off   <= req_laddr[PAGE_BITS-1:0];
          seg   <= req_start_seg;
          cur   <= req_start_seg;
          cnt   <= '0;
          fault <= 1'b0;
          ppage <= cache_hit ? cache_pp : req_start_seg;
        end
        WALK: begin
          if (walk_hit) ppage <= cur;
          else if (walk_end) begin
            last <= cur;
            scan <= hint;
            cnt  <= '0;
          end else if (cnt_max) fault <= 1'b1;
          else begin
            cur <= nxt[cur];
            cnt <= cnt + 1'b1;
          end
        end
        SCAN: begin
          if (!used[scan]) ;
          else if (cnt_max) fault <= 1'b1;
          else begin
            scan <= scan + 1'b1;
            cnt  <= cnt + 1'b1;
          end
        end
        LINK: begin
          ppage <= scan;
          hint  <= scan + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Page 0 is permanently reserved so a zero successor always means end of chain.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      used <= NUM_PAGES'(1);
      for (int i = 0; i < NUM_PAGES; i++) begin
        nxt[i]   <= '0;
        lpage[i] <= '0;
      end
    end else if (state == LINK) begin
      nxt[last]   <= scan;
      nxt[scan]   <= '0;
      lpage[scan] <= tgt;
      used[scan]  <= 1'b1;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_fault = resp_valid && fault;
  assign resp_paddr = (resp_valid && !fault) ? {ppage, off} : '0;

endmodule

// File: doc/mmu_translate.md
Name: mmu_translate

Overview:
- Address-translation stage between the stage1 fetch/decode sequencer and the simple dual-port RAM.
- Accepts a logical address plus the current process's start segment. Walks that process's page chain and returns the physical address.
- On a miss, allocates a free physical page and links it to the end of the chain.
- Replaces the inline event-driven MMU loops with a single-clock, synthesizable FSM.

Parameters:
- ADDR_W, 10, logical and physical address width.
- PAGE_BITS, 3, log2 of page size in words (page = 8 words).
- PAGE_W, ADDR_W-PAGE_BITS, page-index width (derived, not overridable; 128 pages).

Ports:
- rst, input, 1: reset, asynchronous, active-high.
- clka, input, 1: clock; all state updates on posedge clka.
- req_valid, input, 1: translation request present.
- req_ready, output, 1: block can accept a request.
- req_laddr, input, ADDR_W: logical address.
- req_start_seg, input, PAGE_W: physical page holding logical page 0 of the requesting process.
- resp_valid, output, 1: result available; held until consumed.
- resp_ready, input, 1: consumer accepts result.
- resp_paddr, output, ADDR_W: physical address {ppage, laddr[PAGE_BITS-1:0]}.
- resp_fault, output, 1: no free page, or runaway chain; paddr forced to 0.

Behaviour:
- Tables, each NUM_PAGES=2^PAGE_W entries:
  - used[1b]
  - next[PAGE_W]: 0 terminates the chain
  - lpage[PAGE_W]: logical page owned by this entry
- Reset state:
  - all tables 0, except used[0]=1
  - alloc_hint=1, cache invalid, FSM=IDLE
  - req_ready=1, resp_valid=0, resp_paddr=0, resp_fault=0
- Reset mid-operation aborts immediately: the in-flight request is discarded and all tables are reinitialised.
- Handshake:
  - req_ready=1 only in IDLE.
  - A transfer occurs when req_valid&&req_ready at posedge (cycle N).
  - resp_valid stays high with stable data until resp_valid&&resp_ready. The next cycle is IDLE, with req_ready=1.
  - req_valid while not ready is ignored.
- FSM states: IDLE, WALK, SCAN, LINK, RESP.
- IDLE, on accept:
  - Latch tgt=laddr[ADDR_W-1:PAGE_BITS], offset, and seg.
  - If tgt==0: ppage=seg, go to RESP (resp_valid at N+1).
  - If there is a cache hit: go to RESP (resp_valid at N+1).
  - Otherwise: cur=seg, steps=0, go to WALK.
- WALK, examines one entry per cycle:
  - If cur!=seg and lpage[cur]==tgt: ppage=cur, go to RESP.
  - Else if next[cur]==0: last=cur, scan=alloc_hint, cnt=0, go to SCAN.
  - Else if steps==NUM_PAGES-1: fault, go to RESP.
  - Else: cur=next[cur], steps++.
  - Chain position k (seg is k=0) is examined at N+1+k. A hit gives resp_valid at N+2+k.
- SCAN, one entry per cycle:
  - If !used[scan]: go to LINK.
  - Else if cnt==NUM_PAGES-1: fault, go to RESP.
  - Else: scan=scan+1 mod NUM_PAGES, cnt++.
- LINK:
  - next[last]=scan, next[scan]=0, lpage[scan]=tgt, used[scan]=1.
  - alloc_hint=scan+1 mod NUM_PAGES, ppage=scan, go to RESP.
  - With chain length L and s occupied scan slots, resp_valid is at N+L+3+s.
- RESP:
  - Drives the outputs and updates the cache on success.
  - A fault leaves the tables untouched.
- Page 0 is never a successor, so next==0 is unambiguous.
- Pages are never freed by this block.

Optional Feature:
- MMU_CACHE_EN defined:
  - One-entry cache {valid, seg, tgt, ppage}.
  - A hit requires a seg and tgt match and tgt!=0.
  - Filled on every successful non-page-0 response.
- Undefined:
  - No cache; every tgt!=0 request walks the chain.
  - Page 0 remains direct (N+1).

Test Plan:
- After reset, laddr=0x005, seg=0 -> resp_paddr=0x005 and fault=0 at N+1; req_ready low at N+1, high the cycle after resp accepted.
- Then laddr=0x013, seg=0 -> allocates page 1; resp_paddr=0x00B at N+4 (L=1, s=0).
- Then laddr=0x014, seg=0:
  - MMU_CACHE_EN -> 0x00C at N+1.
  - Undefined -> 0x00C at N+3 (walk hit, k=1).
- Then laddr=0x020 -> page 2 allocated, paddr=0x010. Then laddr=0x011 -> walk hit k=1, paddr=0x009 at N+3. Hold resp_ready=0 for 5 cycles -> resp_valid and paddr stable, req_valid ignored.
- Allocate logical pages 1..127 for seg=0 -> all 128 pages used. Then seg=0, laddr page 127 -> hit. Then seg=5, laddr=0x008 -> resp_fault=1, paddr=0, tables unchanged.
- Assert rst while in SCAN -> outputs return to reset values immediately. Re-request laddr=0x013, seg=0 -> re-allocates page 1, paddr=0x00B.
